k_high_pass_filter_mc: RTL

K_HIGH_PASS_FILTER_MC -- requirements
Module: k_high_pass_filter_mc

---
 rtl/k_high_pass_filter_mc_pkg.sv | 38 +++
 rtl/k_high_pass_filter_mc_hpf_core.sv | 113 +++++++++++
 rtl/k_high_pass_filter_mc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/k_high_pass_filter_mc_pkg.sv
// Shared definitions for the multi-channel high-pass filter.
// Contents:
//   state_t    - sequencer state encoding (IDLE, RUN, DRAIN, CLEAR)
//   acc_width  - accumulator width: sample bits + fractional bits + 2 guard bits
//   sat_clamp  - clamps a sign-extended value to a dw-bit signed range and
//                reports whether clamping happened
package k_high_pass_filter_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  function automatic int acc_width(input int dw, input int frac);
    return dw + frac + 2;
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int dw,
                                                   output logic hit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    hit = 1'b0;
    sat_clamp = v;
    if (v > hi) begin
      sat_clamp = hi;
      hit = 1'b1;
    end else if (v < lo) begin
      sat_clamp = lo;
      hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/k_high_pass_filter_mc_hpf_core.sv
// hpf_core: per-channel high-pass arithmetic, two register stages, no filter
// state of its own (previous input/output come in with each sample).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid, in_ch         sample strobe and channel tag
//   x_in                    signed sample
//   x1_in, y1_in            channel's previous scaled input / filter output
//   k_in                    shift (0 = bypass, never 1 here)
//   out_valid, out_ch       result strobe and channel tag, two cycles later
//   out_w1, out_yn          new x_1 / y_1 to store back into the state array
//   y_out, sat_out          saturated output sample and clamp flag
module hpf_core
  import k_high_pass_filter_mc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 32,
  parameter int ACC  = 50,
  parameter int CHW  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [DW-1:0]  x_in,
  input  logic signed [ACC-1:0] x1_in,
  input  logic signed [ACC-1:0] y1_in,
  input  logic [3:0]            k_in,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic signed [ACC-1:0] out_w1,
  output logic signed [ACC-1:0] out_yn,
  output logic signed [DW-1:0]  y_out,
  output logic                  sat_out
);

  logic signed [ACC-1:0] w1_c;
  logic signed [ACC-1:0] w3_c;

  logic                  s1_valid;
  logic [CHW-1:0]        s1_ch;
  logic signed [ACC-1:0] s1_w1;
  logic signed [ACC-1:0] s1_w3;
  logic signed [ACC-1:0] s1_y1;
  logic [3:0]            s1_k;
  logic signed [DW-1:0]  s1_x;

  logic [3:0]            km1;
  logic signed [ACC-1:0] yn_c;
  logic signed [DW+1:0]  yint;
  logic signed [DW-1:0]  ysat_c;
  logic                  hit_c;
  logic                  bypass;

  // Stage 1 front end: scale the sample up to the accumulator format and
  // take the first difference against the stored previous input.
  always_comb begin
    w1_c = {{(ACC-DW-FRAC){x_in[DW-1]}}, x_in, {FRAC{1'b0}}};
    w3_c = w1_c - x1_in;
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_w1    <= '0;
      s1_w3    <= '0;
      s1_y1    <= '0;
      s1_k     <= '0;
      s1_x     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_ch    <= in_ch;
      s1_w1    <= w1_c;
      s1_w3    <= w3_c;
      s1_y1    <= y1_in;
      s1_k     <= k_in;
      s1_x     <= x_in;
    end
  end

  // Stage 2: leaky recursion, integer extraction and saturation. The
  // integer part keeps two extra bits so overflow can be detected.
  always_comb begin
    km1    = s1_k - 4'd1;
    bypass = (s1_k == 4'd0);
    yn_c   = s1_w3 - (s1_w3 >>> s1_k) + s1_y1 - (s1_y1 >>> km1);
    yint   = yn_c[FRAC+DW+1:FRAC];
    ysat_c = DW'(sat_clamp({{(64-DW-2){yint[DW+1]}}, yint}, DW, hit_c));
  end

  // Stage 2 register. In bypass the output follows the input and the stored
  // output state tracks the scaled input, so turning the filter back on
  // starts from a consistent history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_w1    <= '0;
      out_yn    <= '0;
      y_out     <= '0;
      sat_out   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_ch    <= s1_ch;
      out_w1    <= s1_w1;
      out_yn    <= bypass ? s1_w1 : yn_c;
      y_out     <= bypass ? s1_x : ysat_c;
      sat_out   <= bypass ? 1'b0 : hit_c;
    end
  end

endmodule

// File: rtl/k_high_pass_filter_mc.sv
// k_high_pass_filter_mc: NCH-channel first-order high-pass filter sharing one
// pipelined datapath, one channel per cycle.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             gates frame acceptance only
//   clear_state        request to zero all filter state
//   k_sel              filter shift (0 = bypass, 1 treated as 2)
//   x, x_valid, x_ready  input frame, channel i at [i*DW +: DW]
//   y, y_valid         output frame (held between frames), one-cycle strobe
//   sat                per-channel clamp flags for the current frame
//   overrun            sticky: a frame was offered and dropped
module k_high_pass_filter_mc
  import k_high_pass_filter_mc_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int DW        = 16,
  parameter int FRAC      = 32,
  parameter int K_DEFAULT = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_state,
  input  logic [3:0]        k_sel,
  input  logic [NCH*DW-1:0] x,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [NCH*DW-1:0] y,
  output logic              y_valid,
  output logic [NCH-1:0]    sat,
  output logic              overrun
);

  localparam int ACC = acc_width(DW, FRAC);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  state_t            state;
  logic [CHW-1:0]    cnt;
  logic [3:0]        k_reg;
  logic [NCH*DW-1:0] x_frame;
  logic              pend_clr;
  logic              accept;
  logic              drop;

  // Each entry packs {y_1, x_1} for one channel.
  logic [2*ACC-1:0]  state_mem [NCH];

  logic [NCH*DW-1:0] y_shadow;
  logic [NCH*DW-1:0] y_comb;
  logic [NCH-1:0]    sat_shadow;
  logic [NCH-1:0]    sat_comb;

  logic signed [DW-1:0]  core_x;
  logic signed [ACC-1:0] core_x1;
  logic signed [ACC-1:0] core_y1;
  logic                  core_out_valid;
  logic [CHW-1:0]        core_out_ch;
  logic signed [ACC-1:0] core_out_w1;
  logic signed [ACC-1:0] core_out_yn;
  logic signed [DW-1:0]  core_y;
  logic                  core_sat;

  // A clear request in the same cycle wins over an offered frame, so that
  // frame counts as dropped.
  assign x_ready = (state == ST_IDLE) && enable;
  assign accept  = x_valid && x_ready && !clear_state;
  assign drop    = x_valid && !accept;

  assign core_x  = x_frame[cnt*DW +: DW];
  assign core_x1 = state_mem[cnt][ACC-1:0];
  assign core_y1 = state_mem[cnt][2*ACC-1:ACC];

  hpf_core #(
    .DW  (DW),
    .FRAC(FRAC),
    .ACC (ACC),
    .CHW (CHW)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (state == ST_RUN),
    .in_ch    (cnt),
    .x_in     (core_x),
    .x1_in    (core_x1),
    .y1_in    (core_y1),
    .k_in     (k_reg),
    .out_valid(core_out_valid),
    .out_ch   (core_out_ch),
    .out_w1   (core_out_w1),
    .out_yn   (core_out_yn),
    .y_out    (core_y),
    .sat_out  (core_sat)
  );

  // Results land in a shadow copy as they leave the core; the last channel
  // is merged straight in so the whole frame can be published on one edge.
  always_comb begin
    y_comb   = y_shadow;
    sat_comb = sat_shadow;
    if (core_out_valid) begin
      y_comb[core_out_ch*DW +: DW] = core_y;
      sat_comb[core_out_ch]        = core_sat;
    end
  end

  // State array: core writeback during a frame, one channel zeroed per cycle
  // while clearing. The two never overlap because CLEAR only starts after
  // the final writeback edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) state_mem[i] <= '0;
    end else begin
      if (core_out_valid) state_mem[core_out_ch] <= {core_out_yn, core_out_w1};
      if (state == ST_CLEAR) state_mem[cnt] <= '0;
    end
  end

  // Sequencer: RUN feeds one channel per cycle, DRAIN waits out the two
  // pipeline stages, then the frame is published. A clear requested while
  // busy is remembered and run once the frame is out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      k_reg      <= 4'(K_DEFAULT);
      x_frame    <= '0;
      pend_clr   <= 1'b0;
      overrun    <= 1'b0;
      y          <= '0;
      sat        <= '0;
      y_valid    <= 1'b0;
      y_shadow   <= '0;
      sat_shadow <= '0;
    end else begin
      y_valid    <= 1'b0;
      y_shadow   <= y_comb;
      sat_shadow <= sat_comb;
      case (state)
        ST_IDLE: begin
          if (clear_state) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (accept) begin
            state   <= ST_RUN;
            cnt     <= '0;
            k_reg   <= (k_sel == 4'd1) ? 4'd2 : k_sel;
            x_frame <= x;
          end
        end
        ST_RUN: begin
          if (clear_state) pend_clr <= 1'b1;
          if (cnt == LAST_CH) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt == CHW'(1)) begin
            y       <= y_comb;
            sat     <= sat_comb;
            y_valid <= 1'b1;
            cnt     <= '0;
            if (pend_clr || clear_state) begin
              state    <= ST_CLEAR;
              pend_clr <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (clear_state) pend_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST_CH) begin
            cnt     <= '0;
            state   <= ST_IDLE;
            overrun <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
      if (drop) overrun <= 1'b1;
    end
  end

endmodule
